tug_game_core: RTL
==================

# tug_game_core

Game-play core of the tug-of-war design, directly downstream of the 512-cycle slow-enable divider. It consumes the one-cycle `slowen` tick from that divider, samples both players' push buttons once per tick, moves the rope-position LED toward the player who pulled, and declares a winner when the rope reaches either end. It also keeps per-player win scores for the score display.

## Interface
Parameters:
- `HALF`, default 3: LEDs on each side of centre; LED bar width is 2*HALF+1, and the centre index is HALF.

Ports:
- `clk`, in, 1: system clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `slowen`, in, 1: one-`clk`-cycle enable tick from the slow-enable divider; the game advances only in cycles where it is 1.
- `btn_l`, in, 1: left player button, raw and asynchronous; active-high.
- `btn_r`, in, 1: right player button, raw and asynchronous; active-high.
- `clr`, in, 1: new-round request, raw and asynchronous; active-high.
- `leds`, out, 2*HALF+1: LED bar, registered. Bit 2*HALF is the leftmost LED, bit 0 the rightmost.
- `win_l`, out, 1: left player has won the current round; registered.
- `win_r`, out, 1: right player has won the current round; registered.
- `score_l`, out, 4: left player's rounds won; saturates at 15.
- `score_r`, out, 4: right player's rounds won; saturates at 15.

## Operation
- **Input synchronisation:** `btn_l`, `btn_r` and `clr` each pass through a 2-flop synchroniser clocked by `clk`, giving `sl`, `sr` and `sc`.
- **Press detection:** evaluated only when `slowen`=1.
  - `pl` = `sl` & ~`last_l`, where `last_l` <= `sl` on each tick. `pr` is formed the same way from `sr`.
  - Holding a button yields exactly one press.
  - A press shorter than the tick spacing may be missed. This is intentional.
- **Position:** register `pos`, range 0..2*HALF, with reset value HALF. `leds` is one-hot at `pos`, except in the WIN states.
- **States:** IDLE, PLAY, WIN_L, WIN_R. The reset state is IDLE. All transitions occur only on ticks (`slowen`=1).
- **IDLE:** `pos`=HALF.
  - `sc`=1: stay in IDLE.
  - Exactly one of `pl`/`pr`: move one step and go to PLAY.
  - Both or neither: stay in IDLE.
- **PLAY:**
  - `sc`=1: `pos`<=HALF and go to IDLE. Scores are unchanged.
  - `pl` only: `pos`+1. `pr` only: `pos`-1.
  - `pl` and `pr` on the same tick: cancel, no move.
  - If the move reaches `pos`=2*HALF, go to WIN_L on that same tick. If it reaches `pos`=0, go to WIN_R.
- **On entry to WIN_L:** `score_l`+1, saturating at 15, and `win_l`=1. WIN_R mirrors this with `score_r` and `win_r`.
- **WIN_L / WIN_R:**
  - Button presses are ignored.
  - `sc`=1: `pos`<=HALF, `win_*`<=0, go to IDLE.
  - `leds` shows only the winner's end bit (bit 2*HALF for WIN_L, bit 0 for WIN_R).
- **Priority:** `clr` beats any press on the same tick.
- **Scores:** cleared only by `rst`. They are never wrapped.

## Timing
- **Reset values:**
  - `leds` = one-hot bit HALF (7'b0001000 at default).
  - `win_l` = `win_r` = 0.
  - `score_l` = `score_r` = 0.
  - State IDLE; sync and `last` flops 0.
- **Button latency:** a button edge is visible in `sl`/`sr` 2 `clk` cycles after it occurs. It is acted on at the first tick after that. `leds`, `win_*` and `score_*` update on the same edge as the tick, so they are valid in the following cycle.
- **Win timing:** the winning move, `win_*` assertion and score increment all occur on one tick edge.
- **`slowen`=0:** all game state holds; only the synchronisers and flash logic are clocked.
- **Reset mid-round:** asserting `rst` in any state forces every reset value immediately, without waiting for `clk`.

## Configuration
- **`TUG_FLASH_EN` defined:** in WIN_L/WIN_R the winner's end LED toggles on every tick. It is lit in the first cycle after entry and all other bits are 0. Flash phase restarts on each WIN entry.
- **`TUG_FLASH_EN` undefined:** the winner's end LED is steady on for the whole WIN state, and no flash register is built.

## Test plan
All scenarios use HALF=3 and `slowen` pulsed every 8 cycles (shortened for simulation).
- **Reset:** `rst`=0 then release. `leds`=0001000, scores 0/0, `win_l`=`win_r`=0, and outputs are stable with no presses.
- **Left win:** 3 separate left presses, each held over one tick. `leds` steps 0010000, 0100000, 1000000; `win_l`=1 and `score_l`=1 on the third tick; further presses leave all outputs unchanged.
- **Held buttons and ties:** left held across 5 ticks gives exactly one move (`leds`=0010000). Then both buttons pressed on the same tick: no move, state unchanged.
- **Clear:** `clr` pulsed from PLAY at `pos`=5 gives `leds`=0001000 with scores unchanged. `clr` from WIN_R clears `win_r` and keeps `score_r`. `clr` together with a left press in IDLE gives no move.
- **Saturation and async reset:** 16 right wins give `score_r` = 15, held. Asserting `rst` mid-PLAY between clock edges zeroes scores and centres `leds` at once.
- **Flash:** with `TUG_FLASH_EN`, in WIN_L bit 6 alternates 1,0,1 on successive ticks. Without it, bit 6 stays 1.

Source files
------------

// File: rtl/tug_game_core.sv
// Tug-of-war game core: synchronises buttons, moves the rope LED on slow ticks,
// declares a winner at either end and keeps saturating per-player scores.
// Optional build macro TUG_FLASH_EN: flash the winner's end LED on every tick.
module tug_game_core #(
  parameter int unsigned HALF = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                slowen,
  input  logic                btn_l,
  input  logic                btn_r,
  input  logic                clr,
  output logic [2*HALF:0]     leds,
  output logic                win_l,
  output logic                win_r,
  output logic [3:0]          score_l,
  output logic [3:0]          score_r
);

  localparam int unsigned NLED = 2 * HALF + 1;
  localparam int unsigned PW   = $clog2(NLED);
  localparam logic [PW-1:0] POS_C   = PW'(HALF);
  localparam logic [PW-1:0] POS_MAX = PW'(2 * HALF);

  typedef enum logic [1:0] {IDLE, PLAY, WIN_L, WIN_R} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     pos_q, pos_d;
  logic [NLED-1:0]   leds_q, leds_d;
  logic              win_l_q, win_l_d, win_r_q, win_r_d;
  logic [3:0]        score_l_q, score_l_d, score_r_q, score_r_d;
  logic [1:0]        sync_l_q, sync_l_d, sync_r_q, sync_r_d, sync_c_q, sync_c_d;
  logic              last_l_q, last_l_d, last_r_q, last_r_d;
`ifdef TUG_FLASH_EN
  logic              flash_q, flash_d;
`endif

  logic sl_c, sr_c, sc_c, pl_c, pr_c;

  // Synchronised inputs and rising-edge presses as seen on ticks
  assign sl_c = sync_l_q[1];
  assign sr_c = sync_r_q[1];
  assign sc_c = sync_c_q[1];
  assign pl_c = sl_c & ~last_l_q;
  assign pr_c = sr_c & ~last_r_q;

  // Next-state, rope movement, win/score and LED image
  always_comb begin
    logic lit;
    sync_l_d  = {sync_l_q[0], btn_l};
    sync_r_d  = {sync_r_q[0], btn_r};
    sync_c_d  = {sync_c_q[0], clr};
    last_l_d  = last_l_q;
    last_r_d  = last_r_q;
    state_d   = state_q;
    pos_d     = pos_q;
    leds_d    = leds_q;
    win_l_d   = win_l_q;
    win_r_d   = win_r_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
`ifdef TUG_FLASH_EN
    flash_d   = flash_q;
    lit       = 1'b0;
`else
    lit       = 1'b1;
`endif

    if (slowen) begin
      last_l_d = sl_c;
      last_r_d = sr_c;
      case (state_q)
        IDLE, PLAY: begin
          if (sc_c) begin
            state_d = IDLE;
            pos_d   = POS_C;
          end else if (pl_c ^ pr_c) begin
            pos_d   = pl_c ? pos_q + PW'(1) : pos_q - PW'(1);
            state_d = PLAY;
            if (pos_d == POS_MAX) begin
              state_d = WIN_L;
              win_l_d = 1'b1;
              if (score_l_q != 4'd15) score_l_d = score_l_q + 4'd1;
`ifdef TUG_FLASH_EN
              flash_d = 1'b1;
`endif
            end else if (pos_d == '0) begin
              state_d = WIN_R;
              win_r_d = 1'b1;
              if (score_r_q != 4'd15) score_r_d = score_r_q + 4'd1;
`ifdef TUG_FLASH_EN
              flash_d = 1'b1;
`endif
            end
          end
        end
        default: begin
          if (sc_c) begin
            state_d = IDLE;
            pos_d   = POS_C;
            win_l_d = 1'b0;
            win_r_d = 1'b0;
          end else begin
`ifdef TUG_FLASH_EN
            flash_d = ~flash_q;
`endif
          end
        end
      endcase

`ifdef TUG_FLASH_EN
      lit = flash_d;
`endif
      case (state_d)
        WIN_L: begin
          leds_d = '0;
          leds_d[NLED-1] = lit;
        end
        WIN_R: begin
          leds_d = '0;
          leds_d[0] = lit;
        end
        default: leds_d = NLED'(1) << pos_d;
      endcase
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      pos_q     <= POS_C;
      leds_q    <= NLED'(1) << HALF;
      win_l_q   <= 1'b0;
      win_r_q   <= 1'b0;
      score_l_q <= 4'd0;
      score_r_q <= 4'd0;
      sync_l_q  <= 2'b00;
      sync_r_q  <= 2'b00;
      sync_c_q  <= 2'b00;
      last_l_q  <= 1'b0;
      last_r_q  <= 1'b0;
`ifdef TUG_FLASH_EN
      flash_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      leds_q    <= leds_d;
      win_l_q   <= win_l_d;
      win_r_q   <= win_r_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      sync_l_q  <= sync_l_d;
      sync_r_q  <= sync_r_d;
      sync_c_q  <= sync_c_d;
      last_l_q  <= last_l_d;
      last_r_q  <= last_r_d;
`ifdef TUG_FLASH_EN
      flash_q   <= flash_d;
`endif
    end
  end

  assign leds    = leds_q;
  assign win_l   = win_l_q;
  assign win_r   = win_r_q;
  assign score_l = score_l_q;
  assign score_r = score_r_q;

endmodule
